// File: rtl/expr_tx.sv
// expr_tx -- transmit side of the ASCII expression stream.
//
// On an accepted start the block latches up to MAX_TERMS decimal terms and
// the operators between them, then offers them one byte per handshake as
// digit (op digit)*. Digits are 0x30..0x39; '+' is 0x2B and '*' is 0x2A.
// A byte moves on a rising clk edge where valid and ready are both high.
//
// Optional build macro: EXPR_TX_TERM_EN. When it is defined, an '=' (0x3D)
// terminator follows the last digit.
//
// Ports
//   clk        clock; all state changes on the rising edge
//   clr        asynchronous reset, active high
//   start      send request; sampled only while idle
//   terms      term i at bits [4i+3:4i], binary 0..9
//   ops        op i sits between term i and term i+1 (0 = '+', 1 = '*')
//   num_terms  number of terms to send, 1..MAX_TERMS
//   ready      sink accepts the offered byte this cycle
//   char       ASCII byte on offer (0x00 while idle)
//   valid      char is valid
//   busy       transmission in progress
//   done       one-cycle pulse after the last byte is accepted
//   err        one-cycle pulse after a rejected start
module expr_tx #(
    parameter int MAX_TERMS = 4,
    parameter int TERM_W    = 3
) (
    input  logic                   clk,
    input  logic                   clr,
    input  logic                   start,
    input  logic [4*MAX_TERMS-1:0] terms,
    input  logic [MAX_TERMS-2:0]   ops,
    input  logic [TERM_W-1:0]      num_terms,
    input  logic                   ready,
    output logic [7:0]             char,
    output logic                   valid,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    localparam int IW = (MAX_TERMS > 2) ? $clog2(MAX_TERMS) : 1;

`ifdef EXPR_TX_TERM_EN
    typedef enum logic [1:0] {S_IDLE, S_DIG, S_OP, S_TERM} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_DIG, S_OP} state_t;
`endif

    state_t            state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [3:0]        t_q [MAX_TERMS];
    // Operators are padded by one bit so that idx_q can index them over the
    // full term range without a short-array read.
    logic [MAX_TERMS-1:0] o_q;
    logic [TERM_W-1:0] n_q;
    logic              busy_q, done_q, err_q;
    logic              load, done_d, err_d;
    logic              start_ok;
    logic              last;

    // A request is usable only if the count is in range and every term that
    // will actually be sent is a decimal digit; terms past num_terms are
    // don't-care.
    always_comb begin
        start_ok = (num_terms != '0) && (int'(num_terms) <= MAX_TERMS);
        for (int i = 0; i < MAX_TERMS; i++) begin
            if ((i < int'(num_terms)) && (terms[4*i +: 4] > 4'd9))
                start_ok = 1'b0;
        end
    end

    assign last = (int'(idx_q) == (int'(n_q) - 1));

    // Next state. ready only matters while a byte is on offer, which is
    // exactly the non-idle states.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        load    = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (start_ok) begin
                        load    = 1'b1;
                        idx_d   = '0;
                        state_d = S_DIG;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_DIG: begin
                if (ready) begin
                    if (last) begin
`ifdef EXPR_TX_TERM_EN
                        state_d = S_TERM;
`else
                        state_d = S_IDLE;
                        done_d  = 1'b1;
`endif
                    end else begin
                        state_d = S_OP;
                    end
                end
            end
            S_OP: begin
                if (ready) begin
                    idx_d   = idx_q + 1'b1;
                    state_d = S_DIG;
                end
            end
`ifdef EXPR_TX_TERM_EN
            S_TERM: begin
                if (ready) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            o_q     <= '0;
            n_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            for (int i = 0; i < MAX_TERMS; i++) t_q[i] <= 4'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            busy_q  <= (state_d != S_IDLE);
            done_q  <= done_d;
            err_q   <= err_d;
            if (load) begin
                o_q <= {1'b0, ops};
                n_q <= num_terms;
                for (int i = 0; i < MAX_TERMS; i++) t_q[i] <= terms[4*i +: 4];
            end
        end
    end

    // The offered byte is a pure function of the registered state, so it is
    // automatically held stable while the sink stalls, and it drops to 0x00
    // the moment clr forces the state back to idle.
    always_comb begin
        case (state_q)
            S_DIG:   char = {4'h3, t_q[idx_q]};
            S_OP:    char = o_q[idx_q] ? 8'h2A : 8'h2B;
`ifdef EXPR_TX_TERM_EN
            S_TERM:  char = 8'h3D;
`endif
            default: char = 8'h00;
        endcase
    end

    assign valid = (state_q != S_IDLE);
    assign busy  = busy_q;
    assign done  = done_q;
    assign err   = err_q;

endmodule

// File: tb/tb_expr_tx.sv
module tb_expr_tx;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        start = 1'b0;
    logic [15:0] terms = '0;
    logic [2:0]  ops = '0;
    logic [2:0]  num = '0;
    logic        ready = 1'b0;
    logic [7:0]  ch;
    logic        valid, busy, done, err;

    int errors = 0;
    int checks = 0;

    expr_tx #(.MAX_TERMS(4), .TERM_W(3)) dut (
        .clk(clk), .clr(clr), .start(start), .terms(terms), .ops(ops),
        .num_terms(num), .ready(ready), .char(ch), .valid(valid),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A pending request is simply the list of bytes still to be delivered.
    logic [7:0] mq[$];
    logic       m_done = 1'b0, m_err = 1'b0;

    function automatic bit req_ok(input logic [15:0] t, input logic [2:0] n);
        if (n < 1 || n > 4) return 1'b0;
        for (int i = 0; i < int'(n); i++)
            if (t[4*i +: 4] > 4'd9) return 1'b0;
        return 1'b1;
    endfunction

    always @(posedge clk or posedge clr) begin
        if (clr) begin
            mq.delete();
            m_done = 1'b0;
            m_err  = 1'b0;
        end else begin
            m_done = 1'b0;
            m_err  = 1'b0;
            if (mq.size() != 0) begin
                if (ready) begin
                    void'(mq.pop_front());
                    if (mq.size() == 0) m_done = 1'b1;
                end
            end else if (start) begin
                if (req_ok(terms, num)) begin
                    for (int i = 0; i < int'(num); i++) begin
                        mq.push_back(8'h30 + {4'h0, terms[4*i +: 4]});
                        if (i < int'(num) - 1) mq.push_back(ops[i] ? 8'h2A : 8'h2B);
                    end
`ifdef EXPR_TX_TERM_EN
                    mq.push_back(8'h3D);
`endif
                end else begin
                    m_err = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("valid", {31'b0, valid}, {31'b0, mq.size() != 0});
        chk("busy",  {31'b0, busy},  {31'b0, mq.size() != 0});
        chk("done",  {31'b0, done},  {31'b0, m_done});
        chk("err",   {31'b0, err},   {31'b0, m_err});
        if (mq.size() != 0) chk("char", {24'b0, ch}, {24'b0, mq[0]});
    end

    // ---------------- directed helpers ----------------
    logic [7:0] cap[$];
    logic [7:0] eb[$];
    int bcnt, dcnt;

    task automatic send(input logic [15:0] t, input logic [2:0] o, input logic [2:0] n,
                        input int stall);
        cap.delete();
        bcnt = 0;
        dcnt = 0;
        @(negedge clk);
        terms = t; ops = o; num = n; start = 1'b1; ready = (stall == 0);
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (c == stall) ready = 1'b1;
            if (busy) bcnt++;
            if (done) dcnt++;
            if (valid && !ready) begin
                chk("stall_char",  {24'b0, ch}, 32'h31);
                chk("stall_valid", {31'b0, valid}, 32'h1);
            end
            if (valid && ready) cap.push_back(ch);
            if (dcnt > 0) break;
            @(negedge clk);
        end
        chk("stream_done_count", dcnt, 1);
    endtask

    task automatic cmp_basic(input string nm);
        chk({nm, "_len"}, cap.size(), eb.size());
        for (int i = 0; i < eb.size(); i++)
            if (i < cap.size()) chk({nm, "_byte"}, {24'b0, cap[i]}, {24'b0, eb[i]});
    endtask

    task automatic reject(input logic [15:0] t, input logic [2:0] n);
        @(negedge clk);
        terms = t; num = n; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("rej_err",   {31'b0, err},   32'h1);
        chk("rej_valid", {31'b0, valid}, 32'h0);
        chk("rej_busy",  {31'b0, busy},  32'h0);
        @(negedge clk);
        chk("rej_err_pulse", {31'b0, err}, 32'h0);
        chk("rej_valid2",    {31'b0, valid}, 32'h0);
    endtask

    initial begin
        bit got;
        eb = '{8'h31, 8'h2B, 8'h37, 8'h2A, 8'h33};
`ifdef EXPR_TX_TERM_EN
        eb.push_back(8'h3D);
`endif
        #12;
        chk("rst_char",  {24'b0, ch}, 32'h0);
        chk("rst_valid", {31'b0, valid}, 32'h0);
        chk("rst_busy",  {31'b0, busy}, 32'h0);
        chk("rst_done",  {31'b0, done}, 32'h0);
        chk("rst_err",   {31'b0, err}, 32'h0);
        @(negedge clk);
        clr = 1'b0;
        @(negedge clk);

        // Basic stream: 1 + 7 * 3
        send(16'h0371, 3'b010, 3'd3, 0);
        cmp_basic("basic");
        chk("basic_busy_cycles", bcnt, eb.size());

        // Backpressure: three stall cycles on the first byte
        send(16'h0371, 3'b010, 3'd3, 3);
        cmp_basic("bp");
        chk("bp_busy_cycles", bcnt, eb.size() + 3);

        // Rejected starts
        reject(16'h000A, 3'd1);
        reject(16'h0371, 3'd0);
        reject(16'h0371, 3'd5);

        // Out-of-range term past num_terms is ignored
        @(negedge clk);
        terms = 16'hFFF5; num = 3'd1; start = 1'b1; ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("dc_err",   {31'b0, err}, 32'h0);
        chk("dc_valid", {31'b0, valid}, 32'h1);
        chk("dc_char",  {24'b0, ch}, 32'h35);
        repeat (4) @(negedge clk);

        // Ignored start mid-stream, then back-to-back start in the done cycle
        terms = 16'h0371; ops = 3'b010; num = 3'd3; start = 1'b1; ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cap.delete();
        got = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (valid) cap.push_back(ch);
            if (done) begin
                terms = 16'h0009; num = 3'd1; start = 1'b1;
                got = 1'b1;
                break;
            end
            if (c == 1) begin
                start = 1'b1; terms = 16'h0009; num = 3'd1;
            end else if (c == 2) begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        chk("b2b_done_seen", {31'b0, got}, 32'h1);
        cmp_basic("ign");
        @(negedge clk);
        start = 1'b0;
        chk("b2b_valid", {31'b0, valid}, 32'h1);
        chk("b2b_char",  {24'b0, ch}, 32'h39);
        @(negedge clk);
`ifdef EXPR_TX_TERM_EN
        chk("b2b_term", {24'b0, ch}, 32'h3D);
        @(negedge clk);
`endif
        chk("b2b_done", {31'b0, done}, 32'h1);

        // Reset mid-stream, off the clock edge
        @(negedge clk);
        terms = 16'h0371; ops = 3'b010; num = 3'd3; start = 1'b1; ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        #2 clr = 1'b1;
        #1;
        chk("arst_valid", {31'b0, valid}, 32'h0);
        chk("arst_busy",  {31'b0, busy}, 32'h0);
        chk("arst_char",  {24'b0, ch}, 32'h0);
        @(negedge clk);
        clr = 1'b0;
        dcnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        chk("arst_no_done", dcnt, 0);
        send(16'h0005, 3'b000, 3'd1, 0);
        chk("arst_restart_len", cap.size(), 1 + (eb.size() - 5));
        if (cap.size() > 0) chk("arst_restart_char", {24'b0, cap[0]}, 32'h35);

        // Randomised traffic, checked every cycle by the model
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            ready = ($urandom % 4) != 0;
            start = ($urandom % 6) == 0;
            for (int i = 0; i < 4; i++)
                terms[4*i +: 4] = (($urandom % 8) == 0) ? 4'($urandom % 16) : 4'($urandom % 10);
            ops = 3'($urandom % 8);
            num = (($urandom % 5) == 0) ? 3'($urandom % 8) : 3'(1 + ($urandom % 4));
        end
        start = 1'b0;
        ready = 1'b1;
        repeat (12) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
